div_req_ctrl: RTL
=================

DIV_REQ_CTRL -- requirements
Module: div_req_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023: maximum cycles to wait for a divider result.
REQ-002 Parameter GAP_CYC, default 2: minimum cycles div_enable stays low between transactions.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  operand pair offered.
REQ-006 req_ready  output  1  controller accepts operands; high only in IDLE.
REQ-007 req_a  input  32  dividend.
REQ-008 req_b  input  32  divisor.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_q  output  32  quotient, in the divider's output format.
REQ-012 rsp_err  output  2  00 ok, 01 divide-by-zero, 10 timeout.
REQ-013 div_a / div_b  output  32 each  operands driven to the divider.
REQ-014 div_enable  output  1  divider request, level-held.
REQ-015 div_svm_enable  output  1  divider run gate.
REQ-016 div_busy  input  1  divider status; low means result valid while div_enable is high.
REQ-017 div_out  input  32  divider result.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, RELEASE and RESP, with one transaction outstanding at most.
REQ-019 IDLE: on req_valid && req_ready, latch req_a/req_b into div_a/div_b and hold them stable until the next acceptance.
REQ-020 Acceptance with req_b==0: go to RESP with rsp_q=32'hFFFFFFFF and rsp_err=01; div_enable never asserts.
REQ-021 Acceptance with req_a==0 and req_b!=0: go to RESP with rsp_q=0 and rsp_err=00; div_enable never asserts. The divider cannot normalize a zero dividend.
REQ-022 Other acceptances: go to ISSUE, with div_enable=1 starting the cycle after acceptance and the cycle counter cleared.
REQ-023 ISSUE: increment the counter each cycle. On the first cycle with div_busy==0, capture div_out into rsp_q, set rsp_err=00, and go to RELEASE.
REQ-024 ISSUE: if the counter reaches TIMEOUT_CYC-1 with div_busy still high, set rsp_q=0 and rsp_err=10, then go to RELEASE.
REQ-025 If div_busy==0 and the timeout occur in the same cycle, the result SHALL win (rsp_err=00).
REQ-026 RELEASE: div_enable=0. Leave for RESP only after GAP_CYC cycles have elapsed and div_busy==1.
REQ-027 RESP: rsp_valid=1, with rsp_q/rsp_err stable. On rsp_valid && rsp_ready, go to IDLE; new requests are not accepted in that same cycle.
REQ-028 req_ready SHALL equal (state==IDLE); req_valid in any other state SHALL be ignored.
REQ-029 div_svm_enable SHALL be 1 in every state when not in reset.
REQ-030 Latency: acceptance-to-rsp_valid = 1 cycle for REQ-020/021. Otherwise it is 1 + divider cycles + GAP_CYC + 1 minimum.
REQ-031 The counter SHALL be 10 bits wide, saturate and never wrap.

Reset
REQ-032 While rst_n==0: state=IDLE, div_enable=0, div_svm_enable=0, rsp_valid=0, rsp_q=0, rsp_err=00, div_a=div_b=0, counter=0, req_ready=1.
REQ-033 Reset asserted mid-transaction SHALL drop div_enable immediately and discard the transaction with no response. The divider shares rst_n.

Structure
REQ-034 Package div_req_pkg SHALL hold the state enum, the rsp_err codes, and the TIMEOUT_CYC/GAP_CYC defaults.
REQ-035 The block SHALL be a single FSM module with no sub-module. It pairs with the existing divider block div_cal, which is instantiated beside it at top level.

Verification
REQ-036 Use a bench responder model with div_busy low 40 cycles after div_enable rises and div_out=0x00010000. Request a=0x00008000, b=0x00004000 -> rsp_q=0x00010000, rsp_err=00, div_enable high 40 cycles then low for at least 2 cycles.
REQ-037 Request b=0, a=0x1234 -> no div_enable pulse, rsp_valid one cycle after acceptance, rsp_q=0xFFFFFFFF, rsp_err=01.
REQ-038 Request a=0, b=5 -> no div_enable pulse, rsp_q=0, rsp_err=00.
REQ-039 Model holds div_busy=1 forever -> div_enable drops after 1023 cycles, rsp_q=0, rsp_err=10.
REQ-040 Hold rsp_ready=0 for 10 cycles while req_valid=1 -> rsp_q/rsp_err stable, req_ready=0, no second acceptance.
REQ-041 Assert rst_n=0 at cycle 20 of ISSUE -> div_enable=0 without waiting for a clk edge, rsp_valid=0, req_ready=1 after release.

Source files
------------

// File: rtl/div_req_pkg.sv
// Shared types and constants for the divider request controller.
//   state_e      : controller FSM states
//   rsp_err codes: ErrOk / ErrDivZero / ErrTimeout
//   defaults     : TimeoutCycDefault / GapCycDefault, counter width
package div_req_pkg;

  localparam int unsigned TimeoutCycDefault = 1023;
  localparam int unsigned GapCycDefault     = 2;

  // Wait counter; saturates at its all-ones value.
  localparam int unsigned CntW   = 10;
  localparam int unsigned CntMax = (1 << CntW) - 1;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrDivZero = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRelease,
    StResp
  } state_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/div_req_ctrl.sv
// Request/response front end for the div_cal divider.
// Accepts one operand pair at a time, resolves zero divisor / zero dividend
// locally, otherwise holds div_enable until the divider drops div_busy (or a
// timeout expires), enforces a minimum low gap on div_enable, then presents
// the result until the consumer takes it.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready/req_a/b    operand request handshake
//   rsp_valid/rsp_ready/rsp_q/err  result handshake (err: 00 ok, 01 /0, 10 timeout)
//   div_a/div_b                    operands held stable for the divider
//   div_enable, div_svm_enable     divider request level and run gate
//   div_busy, div_out              divider status and result
module div_req_ctrl
  import div_req_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault,
  parameter int unsigned GAP_CYC     = GapCycDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_q,
  output logic [1:0]  rsp_err,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_enable,
  output logic        div_svm_enable,
  input  logic        div_busy,
  input  logic [31:0] div_out
);

  // Last counter value of a phase; zero-length settings still spend one cycle.
  localparam int unsigned TimeoutLastInt =
      (TIMEOUT_CYC == 0) ? 0 : ((TIMEOUT_CYC - 1 > CntMax) ? CntMax : TIMEOUT_CYC - 1);
  localparam int unsigned GapLastInt =
      (GAP_CYC == 0) ? 0 : ((GAP_CYC - 1 > CntMax) ? CntMax : GAP_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutLastInt);
  localparam logic [CntW-1:0] GapLast     = CntW'(GapLastInt);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     div_a_q, div_a_d;
  logic [31:0]     div_b_q, div_b_d;
  logic [31:0]     rsp_q_q, rsp_q_d;
  logic [1:0]      rsp_err_q, rsp_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      rsp_q_q   <= '0;
      rsp_err_q <= ErrOk;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      rsp_q_q   <= rsp_q_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    rsp_q_d   = rsp_q_q;
    rsp_err_d = rsp_err_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          div_a_d = req_a;
          div_b_d = req_b;
          cnt_d   = '0;
          if (req_b == '0) begin
            rsp_q_d   = '1;
            rsp_err_d = ErrDivZero;
            state_d   = StResp;
          end else if (req_a == '0) begin
            // The divider cannot normalize a zero dividend; answer locally.
            rsp_q_d   = '0;
            rsp_err_d = ErrOk;
            state_d   = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        cnt_d = sat_inc(cnt_q);
        // Result is checked first so it wins over a coincident timeout.
        if (!div_busy) begin
          rsp_q_d   = div_out;
          rsp_err_d = ErrOk;
          cnt_d     = '0;
          state_d   = StRelease;
        end else if (cnt_q >= TimeoutLast) begin
          rsp_q_d   = '0;
          rsp_err_d = ErrTimeout;
          cnt_d     = '0;
          state_d   = StRelease;
        end
      end

      StRelease: begin
        cnt_d = sat_inc(cnt_q);
        // div_busy high means the divider has seen the enable drop.
        if ((cnt_q >= GapLast) && div_busy) begin
          state_d = StResp;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Decoded from state so an async reset drops div_enable without a clock edge.
  assign req_ready      = (state_q == StIdle);
  assign rsp_valid      = (state_q == StResp);
  assign div_enable     = (state_q == StIssue);
  assign div_svm_enable = rst_n;

  assign div_a   = div_a_q;
  assign div_b   = div_b_q;
  assign rsp_q   = rsp_q_q;
  assign rsp_err = rsp_err_q;

endmodule
